// File: rtl/reg_cmd_initiator.sv
// reg_cmd_initiator: queues load/inc/clr commands, strobes them into a register and checks the read-back.
module reg_cmd_initiator #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             reg_load,
  output logic             reg_inc,
  output logic             reg_clr,
  output logic [WIDTH-1:0] reg_indata,
  input  logic [WIDTH-1:0] reg_outdata,
  output logic             busy,
  output logic             mismatch,
  output logic [WIDTH-1:0] expected,
  output logic [15:0]      err_count,
  output logic [AW:0]      level
);
  typedef enum logic [1:0] {IDLE, ISSUE, CHECK} state_t;
  state_t state, state_nx;
  logic [1:0]       op_mem [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [1:0]       hold_op;
  logic [WIDTH-1:0] hold_data;
  logic             push, pop, fail;
  assign cmd_ready = rst_n & (level != (AW+1)'(DEPTH));
  // no-ops finish the handshake but never occupy a slot
  assign push = cmd_valid & cmd_ready & (cmd_op != 2'b00);
  assign busy = (state != IDLE) | (level != '0);
  assign fail = (state == CHECK) & (reg_outdata != expected);
  always_comb begin
    state_nx   = state;
    pop        = 1'b0;
    reg_load   = 1'b0;
    reg_inc    = 1'b0;
    reg_clr    = 1'b0;
    reg_indata = '0;
    case (state)
      IDLE: begin
        pop      = level != '0;
        state_nx = pop ? ISSUE : IDLE;
      end
      ISSUE: begin
        reg_load   = hold_op == 2'b01;
        reg_clr    = hold_op == 2'b10;
        reg_inc    = hold_op == 2'b11;
        reg_indata = reg_load ? hold_data : '0;
        state_nx   = CHECK;
      end
      CHECK: begin
        pop      = level != '0;
        state_nx = pop ? ISSUE : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr]   <= cmd_op;
      data_mem[wr_ptr] <= cmd_data;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      hold_op   <= 2'b00;
      hold_data <= '0;
      expected  <= '0;
      mismatch  <= 1'b0;
      err_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        hold_op   <= op_mem[rd_ptr];
        hold_data <= data_mem[rd_ptr];
      end
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
      // inc expectation comes from the live pre-increment value, so the register needs no reset
      if (state == ISSUE)
        expected <= hold_op == 2'b01 ? hold_data :
                    hold_op == 2'b11 ? reg_outdata + WIDTH'(1) : '0;
      mismatch <= fail;
      if (fail && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_reg_cmd_initiator.sv
// tb_reg_cmd_initiator: directed scenarios against a behavioural load/inc/clr register.
module tb_reg_cmd_initiator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [15:0] cmd_data = '0;
  logic        reg_load, reg_inc, reg_clr;
  logic [15:0] reg_indata, reg_outdata;
  logic        busy, mismatch;
  logic [15:0] expected, err_count;
  logic [2:0]  level;
  logic [15:0] r = '0;
  logic        fault = 1'b0;
  int          cyc = 0;
  int          n_cmp = 0, n_fail = 0;
  int          stalls, push_cyc, mm, multi, maxlvl;
  logic [1:0]  log_kind[$];
  logic [15:0] log_data[$];
  int          log_cyc[$];

  reg_cmd_initiator #(.WIDTH(16), .DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .reg_load(reg_load), .reg_inc(reg_inc),
    .reg_clr(reg_clr), .reg_indata(reg_indata), .reg_outdata(reg_outdata),
    .busy(busy), .mismatch(mismatch), .expected(expected), .err_count(err_count),
    .level(level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (reg_clr)       r <= '0;
    else if (reg_load) r <= reg_indata;
    else if (reg_inc)  r <= r + 16'd1;
  end
  assign reg_outdata = fault ? 16'h0001 : r;

  always @(negedge clk) begin
    if (reg_load || reg_inc || reg_clr) begin
      log_kind.push_back(reg_load ? 2'd1 : reg_clr ? 2'd2 : 2'd3);
      log_data.push_back(reg_indata);
      log_cyc.push_back(cyc);
    end
    if (int'(reg_load) + int'(reg_inc) + int'(reg_clr) > 1) multi++;
    if (mismatch) mm++;
    if (int'(level) > maxlvl) maxlvl = int'(level);
  end

  task automatic clear_logs();
    log_kind.delete();
    log_data.delete();
    log_cyc.delete();
    stalls = 0;
    mm = 0;
    maxlvl = 0;
  endtask

  task automatic push(input logic [1:0] op, input logic [15:0] d);
    int w;
    w = 0;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = d;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    stalls += w;
    if (w == 20) begin
      n_cmp++;
      n_fail++;
      $display("FAIL push_timeout got ready=%b want 1", cmd_ready);
    end
    @(negedge clk);
    push_cyc = cyc;
  endtask

  task automatic idle();
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_data = '0;
  endtask

  task automatic wait_quiet();
    int k;
    k = 0;
    while ((busy || mismatch) && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (k == 60) begin
      n_cmp++;
      n_fail++;
      $display("FAIL quiet_timeout got busy=%b want 0", busy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b1;
    cmd_op = 2'b01;
    cmd_data = 16'h1111;
    repeat (3) @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", cmd_ready); end
    n_cmp++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if ({reg_load, reg_inc, reg_clr} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes got %b want 000", {reg_load, reg_inc, reg_clr}); end
    n_cmp++; if (reg_indata !== 16'h0) begin n_fail++; $display("FAIL reset_indata got %h want 0000", reg_indata); end
    n_cmp++; if (expected !== 16'h0) begin n_fail++; $display("FAIL reset_expected got %h want 0000", expected); end
    n_cmp++; if (err_count !== 16'h0) begin n_fail++; $display("FAIL reset_err got %0d want 0", err_count); end
    n_cmp++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL reset_mismatch got %b want 0", mismatch); end
    idle();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load();
    clear_logs();
    push(2'b01, 16'hA5A5);
    idle();
    wait_quiet();
    n_cmp++; if (log_kind.size() !== 1) begin n_fail++; $display("FAIL load_count got %0d want 1", log_kind.size()); end
    if (log_kind.size() == 1) begin
      n_cmp++; if (log_kind[0] !== 2'd1) begin n_fail++; $display("FAIL load_kind got %0d want 1", log_kind[0]); end
      n_cmp++; if (log_data[0] !== 16'hA5A5) begin n_fail++; $display("FAIL load_indata got %h want a5a5", log_data[0]); end
      n_cmp++; if (log_cyc[0] - push_cyc !== 1) begin n_fail++; $display("FAIL load_latency got %0d want 1", log_cyc[0] - push_cyc); end
    end
    n_cmp++; if (expected !== 16'hA5A5) begin n_fail++; $display("FAIL load_expected got %h want a5a5", expected); end
    n_cmp++; if (mm !== 0) begin n_fail++; $display("FAIL load_mismatch got %0d want 0", mm); end
    n_cmp++; if (err_count !== 16'h0) begin n_fail++; $display("FAIL load_err got %0d want 0", err_count); end
  endtask

  task automatic test_inc_wrap();
    clear_logs();
    push(2'b01, 16'hFFFF);
    push(2'b11, 16'h0000);
    idle();
    wait_quiet();
    n_cmp++; if (log_kind.size() !== 2) begin n_fail++; $display("FAIL wrap_count got %0d want 2", log_kind.size()); end
    if (log_kind.size() == 2) begin
      n_cmp++; if (log_kind[1] !== 2'd3) begin n_fail++; $display("FAIL wrap_kind got %0d want 3", log_kind[1]); end
      n_cmp++; if (log_data[1] !== 16'h0) begin n_fail++; $display("FAIL wrap_indata got %h want 0000", log_data[1]); end
    end
    n_cmp++; if (expected !== 16'h0000) begin n_fail++; $display("FAIL wrap_expected got %h want 0000", expected); end
    n_cmp++; if (mm !== 0) begin n_fail++; $display("FAIL wrap_mismatch got %0d want 0", mm); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] want [4];
    want = '{2'd1, 2'd3, 2'd3, 2'd2};
    clear_logs();
    push(2'b01, 16'd5);
    push(2'b11, 16'd0);
    push(2'b11, 16'd0);
    push(2'b10, 16'd0);
    idle();
    wait_quiet();
    n_cmp++; if (stalls !== 0) begin n_fail++; $display("FAIL b2b_stalls got %0d want 0", stalls); end
    n_cmp++; if (maxlvl !== 2) begin n_fail++; $display("FAIL b2b_maxlevel got %0d want 2", maxlvl); end
    n_cmp++; if (log_kind.size() !== 4) begin n_fail++; $display("FAIL b2b_count got %0d want 4", log_kind.size()); end
    if (log_kind.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (log_kind[i] !== want[i]) begin n_fail++; $display("FAIL b2b_kind%0d got %0d want %0d", i, log_kind[i], want[i]); end
      end
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (log_cyc[i+1] - log_cyc[i] !== 2) begin n_fail++; $display("FAIL b2b_spacing%0d got %0d want 2", i, log_cyc[i+1] - log_cyc[i]); end
      end
      n_cmp++; if (log_data[0] !== 16'd5) begin n_fail++; $display("FAIL b2b_indata got %h want 0005", log_data[0]); end
    end
    n_cmp++; if (expected !== 16'h0) begin n_fail++; $display("FAIL b2b_expected got %h want 0000", expected); end
    n_cmp++; if (err_count !== 16'h0) begin n_fail++; $display("FAIL b2b_err got %0d want 0", err_count); end
  endtask

  task automatic test_full();
    clear_logs();
    push(2'b01, 16'd1);
    for (int i = 0; i < 7; i++) push(2'b11, 16'd0);
    idle();
    wait_quiet();
    n_cmp++; if (stalls !== 1) begin n_fail++; $display("FAIL full_stalls got %0d want 1", stalls); end
    n_cmp++; if (maxlvl !== 4) begin n_fail++; $display("FAIL full_maxlevel got %0d want 4", maxlvl); end
    n_cmp++; if (log_kind.size() !== 8) begin n_fail++; $display("FAIL full_count got %0d want 8", log_kind.size()); end
    n_cmp++; if (expected !== 16'd8) begin n_fail++; $display("FAIL full_expected got %h want 0008", expected); end
    n_cmp++; if (mm !== 0) begin n_fail++; $display("FAIL full_mismatch got %0d want 0", mm); end
  endtask

  task automatic test_noop();
    clear_logs();
    push(2'b00, 16'h0099);
    idle();
    n_cmp++; if (stalls !== 0) begin n_fail++; $display("FAIL noop_handshake got %0d want 0", stalls); end
    n_cmp++; if (level !== 3'd0) begin n_fail++; $display("FAIL noop_level got %0d want 0", level); end
    repeat (4) @(negedge clk);
    n_cmp++; if (log_kind.size() !== 0) begin n_fail++; $display("FAIL noop_strobe got %0d want 0", log_kind.size()); end
    clear_logs();
    push(2'b01, 16'd7);
    push(2'b00, 16'h0099);
    push(2'b01, 16'd9);
    idle();
    wait_quiet();
    n_cmp++; if (log_kind.size() !== 2) begin n_fail++; $display("FAIL noop_count got %0d want 2", log_kind.size()); end
    if (log_kind.size() == 2) begin
      n_cmp++; if (log_data[0] !== 16'd7) begin n_fail++; $display("FAIL noop_first got %h want 0007", log_data[0]); end
      n_cmp++; if (log_data[1] !== 16'd9) begin n_fail++; $display("FAIL noop_second got %h want 0009", log_data[1]); end
    end
    n_cmp++; if (expected !== 16'd9) begin n_fail++; $display("FAIL noop_expected got %h want 0009", expected); end
  endtask

  task automatic test_fault();
    fault = 1'b1;
    clear_logs();
    push(2'b01, 16'h1234);
    idle();
    wait_quiet();
    n_cmp++; if (mm !== 1) begin n_fail++; $display("FAIL fault_load_pulse got %0d want 1", mm); end
    n_cmp++; if (err_count !== 16'd1) begin n_fail++; $display("FAIL fault_load_err got %0d want 1", err_count); end
    n_cmp++; if (expected !== 16'h1234) begin n_fail++; $display("FAIL fault_load_expected got %h want 1234", expected); end
    clear_logs();
    push(2'b10, 16'h0);
    idle();
    wait_quiet();
    n_cmp++; if (mm !== 1) begin n_fail++; $display("FAIL fault_clr_pulse got %0d want 1", mm); end
    n_cmp++; if (err_count !== 16'd2) begin n_fail++; $display("FAIL fault_clr_err got %0d want 2", err_count); end
    n_cmp++; if (expected !== 16'h0) begin n_fail++; $display("FAIL fault_clr_expected got %h want 0000", expected); end
    fault = 1'b0;
  endtask

  task automatic test_reset_mid();
    clear_logs();
    push(2'b01, 16'd10);
    for (int i = 0; i < 5; i++) push(2'b11, 16'd0);
    n_cmp++; if (reg_inc !== 1'b1) begin n_fail++; $display("FAIL mid_issue_inc got %b want 1", reg_inc); end
    n_cmp++; if (level !== 3'd3) begin n_fail++; $display("FAIL mid_issue_level got %0d want 3", level); end
    rst_n = 1'b0;
    cmd_op = 2'b01;
    cmd_data = 16'h0055;
    @(negedge clk);
    n_cmp++; if ({reg_load, reg_inc, reg_clr} !== 3'b000) begin n_fail++; $display("FAIL mid_strobes got %b want 000", {reg_load, reg_inc, reg_clr}); end
    n_cmp++; if (level !== 3'd0) begin n_fail++; $display("FAIL mid_level got %0d want 0", level); end
    n_cmp++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL mid_err got %0d want 0", err_count); end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready got %b want 0", cmd_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b want 0", busy); end
    @(negedge clk);
    n_cmp++; if (level !== 3'd0) begin n_fail++; $display("FAIL mid_push_ignored got %0d want 0", level); end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready_held got %b want 0", cmd_ready); end
    idle();
    rst_n = 1'b1;
    clear_logs();
    repeat (6) @(negedge clk);
    n_cmp++; if (mm !== 0) begin n_fail++; $display("FAIL mid_no_mismatch got %0d want 0", mm); end
    n_cmp++; if (log_kind.size() !== 0) begin n_fail++; $display("FAIL mid_no_strobe got %0d want 0", log_kind.size()); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_back got %b want 1", cmd_ready); end
  endtask

  initial begin
    multi = 0;
    clear_logs();
    @(negedge clk);
    test_reset();
    test_load();
    test_inc_wrap();
    test_back_to_back();
    test_full();
    test_noop();
    test_fault();
    test_reset_mid();
    n_cmp++; if (multi !== 0) begin n_fail++; $display("FAIL single_strobe got %0d want 0", multi); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_cmd_initiator.md
Name: reg_cmd_initiator

Overview:
- Command initiator for the load/inc/clr register port. It is the driving end of the interface the 16-bit register responds to.
- Accepts queued register commands over a valid/ready handshake, issues each one as a single-cycle load/inc/clr strobe, then reads the register output back and checks it against the expected result.
- Sits between the control sequencer and any load/inc/clr register. Reports mismatches and keeps a saturating error count.

Parameters:
- WIDTH, 16, data width of the register and of cmd_data.
- DEPTH, 4, command FIFO depth; must be a power of 2, at least 2.
- AW, 2, FIFO pointer width; equals log2(DEPTH).

Ports:
- clk  in  1  single system clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_op  in  2  command code: 01 load, 10 clr, 11 inc, 00 no-op.
- cmd_data  in  WIDTH  load value; ignored for other ops.
- reg_load  out  1  register load strobe.
- reg_inc  out  1  register increment strobe.
- reg_clr  out  1  register clear strobe.
- reg_indata  out  WIDTH  register input data.
- reg_outdata  in  WIDTH  register output, read back for checking.
- busy  out  1  FSM not in IDLE, or FIFO non-empty.
- mismatch  out  1  one-cycle pulse when a read-back check fails.
- expected  out  WIDTH  value the last check compared against.
- err_count  out  16  saturating count of failed checks.
- level  out  AW+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n low at posedge):
  - FIFO emptied; level=0; FSM goes to IDLE.
  - All strobes 0; reg_indata=0; expected=0; mismatch=0; err_count=0.
  - cmd_ready is forced 0 while rst_n is low, and pushes are ignored.
  - Reset mid-operation abandons the in-flight command without a check. Any strobe already sampled by the register stands.
- Handshake and FIFO:
  - cmd_ready = (level != DEPTH). It is combinational from the registered level, with no full-bypass.
  - A transfer happens on a posedge with cmd_valid & cmd_ready.
  - op 00 completes the handshake but is not written into the FIFO.
  - Simultaneous push and pop leaves level unchanged.
  - Pointers wrap modulo DEPTH.
  - cmd_valid while full: held off and not lost; the source keeps it asserted.
- FSM states: IDLE, ISSUE, CHECK.
  - IDLE: if level>0, pop the head entry into an op/data holding register and go to ISSUE; otherwise stay.
  - ISSUE (exactly 1 cycle): drive exactly one strobe matching the op; reg_indata = held data for load, otherwise 0. On this edge the register executes. Also latch:
    - load: expected = data.
    - clr: expected = 0.
    - inc: expected = (reg_outdata sampled this cycle) + 1, truncated to WIDTH. 0xFFFF wraps to 0x0000.
  - ISSUE then goes to CHECK. All strobes are 0 in every state except ISSUE.
  - CHECK (1 cycle): compare reg_outdata with expected. On the edge, mismatch <= (reg_outdata != expected), and err_count increments on mismatch, saturating at 0xFFFF.
  - From CHECK: if level>0, pop and go directly to ISSUE; otherwise go to IDLE.
- Timing:
  - Throughput is one command per 2 cycles.
  - Latency from handshake to strobe: 2 cycles with an empty FIFO and the FSM idle (push edge, pop edge, then strobe during ISSUE).
  - mismatch is valid for the cycle after CHECK and deasserts on the next edge unless another CHECK fails.
- busy is registered-state derived: (state != IDLE) | (level != 0).
- The register under test has no reset. The inc check uses the read-back prior value, so no shadow copy needs initialising.

Test Plan:
- Reset, then push load 0xA5A5: reg_load high for exactly one cycle with reg_indata=0xA5A5 → expected=0xA5A5, mismatch stays 0, err_count=0.
- Push load 0xFFFF then inc: second strobe is reg_inc → expected=0x0000 (wrap), no mismatch.
- Back-to-back load 5, inc, inc, clr pushed on consecutive cycles with DEPTH=4:
  - cmd_ready drops only when level=4.
  - Strobes appear every 2nd cycle, in order load, inc, inc, clr.
  - Final expected=0 and err_count=0.
- Faulty register model (reg_outdata stuck at 0x0001), then load 0x1234 → mismatch pulses 1 cycle and err_count=1. A following clr raises mismatch again and err_count=2.
- Op 00 pushed between two loads: handshake completes, level does not change, and no strobe is issued for it.
- Assert rst_n low during ISSUE of a queued inc with 3 entries pending:
  - Next cycle: all strobes 0, level=0, err_count=0, cmd_ready=0 until rst_n is high.
  - No mismatch afterwards.
